// File: rtl/out_buf_drain_pkg.sv
// Shared definitions for the output-buffer drain path: FSM encoding, lane order
// and width defaults common to data_pack / out_addr_rdy / out_buf_drain.
package out_buf_drain_pkg;

    localparam int unsigned OBD_ADDR_W = 16;
    localparam int unsigned OBD_LANE_W = 16;
    localparam int unsigned OBD_LANES  = 4;
    localparam int unsigned OBD_DATA_W = OBD_LANES * OBD_LANE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } drain_state_e;

    typedef enum logic {
        LANE_MSB_FIRST = 1'b0,
        LANE_LSB_FIRST = 1'b1
    } lane_order_e;

    localparam lane_order_e OBD_LANE_ORDER = LANE_MSB_FIRST;

    // Maps a stream lane index to its slot within the packed word.
    function automatic int unsigned lane_slot(input int unsigned lane, input int unsigned lanes);
        return (OBD_LANE_ORDER == LANE_MSB_FIRST) ? (lanes - 1 - lane) : lane;
    endfunction

endpackage

// File: rtl/out_buf_drain_word_fifo.sv
// drain_word_fifo: 2-entry word FIFO with occupancy count; push while full is
// accepted only when a pop happens in the same cycle.
module drain_word_fifo #(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] dout_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        cnt_q;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        do_pop  = pop_i && (cnt_q != 2'd0);
        do_push = push_i && ((cnt_q != 2'd2) || do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign dout_o  = (cnt_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/out_buf_drain.sv
// out_buf_drain: reads packed partial-sum words from the output buffer and streams
// them lane by lane. Optional OUT_DRAIN_CLEAR_EN zeroes each word after reading it.
module out_buf_drain
    import out_buf_drain_pkg::*;
#(
    parameter int unsigned ADDR_W = OBD_ADDR_W,
    parameter int unsigned DATA_W = OBD_DATA_W,
    parameter int unsigned LANE_W = OBD_LANE_W,
    parameter int unsigned LANES  = OBD_LANES,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_words,
    output logic              ram_ena,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wea,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned LCW = (LANES > 1) ? $clog2(LANES) : 1;

    drain_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rd_left_q, rd_left_d;
    logic [ADDR_W-1:0] words_left_q, words_left_d;
    logic [LCW-1:0]    lane_q, lane_d;
    logic [1:0]        inflight_q, inflight_d;
    logic [RD_LAT-1:0] vld_q;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef OUT_DRAIN_CLEAR_EN
    logic              clr_pend_q, clr_pend_d;
`endif

    logic              rd_issue;
    logic              fifo_push;
    logic              fifo_pop;
    logic              xfer;
    logic              last_lane;
    logic              credit_ok;
    logic [1:0]        fifo_cnt;
    logic [DATA_W-1:0] head;

    drain_word_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (fifo_push),
        .din_i  (ram_dout),
        .pop_i  (fifo_pop),
        .dout_o (head),
        .count_o(fifo_cnt)
    );

    always_comb begin
        fifo_push    = vld_q[RD_LAT-1];
        xfer         = (fifo_cnt != 2'd0) && out_ready;
        last_lane    = (lane_q == LCW'(LANES - 1));
        fifo_pop     = xfer && last_lane;
        lane_d       = xfer ? (last_lane ? '0 : lane_q + 1'b1) : lane_q;
        words_left_d = fifo_pop ? words_left_q - 1'b1 : words_left_q;
        // Reads already in the RAM pipeline reserve FIFO space before data returns.
        credit_ok    = ({1'b0, fifo_cnt} + {1'b0, inflight_q}) < 3'd2;

        state_d   = state_q;
        addr_d    = addr_q;
        rd_left_d = rd_left_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_issue  = 1'b0;
        ram_ena   = 1'b0;
        ram_addr  = '0;
        ram_wea   = '0;
`ifdef OUT_DRAIN_CLEAR_EN
        clr_pend_d = clr_pend_q;
`endif

        case (state_q)
            IDLE: begin
                // The first read goes out in the start cycle itself.
                if (start && !rst) begin
                    busy_d       = 1'b1;
                    words_left_d = num_words;
                    if (num_words == '0) begin
                        state_d = DONE;
                    end else begin
                        rd_issue  = 1'b1;
                        ram_ena   = 1'b1;
                        ram_addr  = base_addr;
                        rd_left_d = num_words - 1'b1;
`ifdef OUT_DRAIN_CLEAR_EN
                        addr_d     = base_addr;
                        clr_pend_d = 1'b1;
                        state_d    = READ;
`else
                        addr_d  = base_addr + 1'b1;
                        state_d = (num_words == ADDR_W'(1)) ? FLUSH : READ;
`endif
                    end
                end
            end
            READ: begin
`ifdef OUT_DRAIN_CLEAR_EN
                if (clr_pend_q) begin
                    ram_ena    = 1'b1;
                    ram_wea    = '1;
                    ram_addr   = addr_q;
                    addr_d     = addr_q + 1'b1;
                    clr_pend_d = 1'b0;
                    if (rd_left_q == '0) begin
                        state_d = FLUSH;
                    end
                end else if (credit_ok) begin
                    rd_issue   = 1'b1;
                    ram_ena    = 1'b1;
                    ram_addr   = addr_q;
                    rd_left_d  = rd_left_q - 1'b1;
                    clr_pend_d = 1'b1;
                end
`else
                if (credit_ok) begin
                    rd_issue  = 1'b1;
                    ram_ena   = 1'b1;
                    ram_addr  = addr_q;
                    addr_d    = addr_q + 1'b1;
                    rd_left_d = rd_left_q - 1'b1;
                    if (rd_left_q == ADDR_W'(1)) begin
                        state_d = FLUSH;
                    end
                end
`endif
            end
            FLUSH: begin
                if ((inflight_q == 2'd0) && (fifo_cnt == 2'd0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        case ({rd_issue, fifo_push})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rd_left_q    <= '0;
            words_left_q <= '0;
            lane_q       <= '0;
            inflight_q   <= 2'd0;
            vld_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef OUT_DRAIN_CLEAR_EN
            clr_pend_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rd_left_q    <= rd_left_d;
            words_left_q <= words_left_d;
            lane_q       <= lane_d;
            inflight_q   <= inflight_d;
            vld_q[0]     <= rd_issue;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef OUT_DRAIN_CLEAR_EN
            clr_pend_q   <= clr_pend_d;
`endif
        end
    end

    assign ram_din   = '0;
    assign out_valid = (fifo_cnt != 2'd0);
    assign out_data  = head[lane_slot(32'(lane_q), LANES) * LANE_W +: LANE_W];
    assign out_last  = out_valid && last_lane && (words_left_q == ADDR_W'(1));
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_out_buf_drain.sv
// Self-checking bench for out_buf_drain with a behavioural RAM and a lane-stream model.
`timescale 1ns/1ps
module tb_out_buf_drain;

    localparam int unsigned RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] num_words;
    logic        ram_ena;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wea;
    logic [63:0] ram_din;
    logic [63:0] ram_dout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    out_buf_drain #(
        .ADDR_W(16), .DATA_W(64), .LANE_W(16), .LANES(4), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
        .ram_ena(ram_ena), .ram_addr(ram_addr), .ram_wea(ram_wea), .ram_din(ram_din),
        .ram_dout(ram_dout), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // RAM model, with a bench-side preload port used only while the DUT is idle.
    logic [63:0] mem [0:65535];
    logic [63:0] ref_mem [logic [15:0]];
    logic        tb_we = 1'b0;
    logic [15:0] tb_wa = '0;
    logic [63:0] tb_wd = '0;
    logic [63:0] rd_p1, rd_p2;

    function automatic logic [63:0] byte_mask(input logic [7:0] we);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{we[b]}};
        return m;
    endfunction

    always @(posedge clk) begin
        if (tb_we) begin
            mem[tb_wa] <= tb_wd;
        end else if (ram_ena) begin
            rd_p1 <= mem[ram_addr];
            if (ram_wea != 8'h00)
                mem[ram_addr] <= (mem[ram_addr] & ~byte_mask(ram_wea)) | (ram_din & byte_mask(ram_wea));
        end
        rd_p2 <= rd_p1;
    end
    assign ram_dout = (RD_LAT == 2) ? rd_p2 : rd_p1;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int ready_mode = 0;
    int rphase = 0;
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin out_ready = (rphase == 0); rphase = (rphase + 1) % 3; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Mid-cycle monitor.
    int          start_cyc, first_valid_cyc, done_cyc, done_cnt;
    int          issued, consumed, outst_max, stall_err, wea_cnt;
    bit          valid_seen, prev_stall;
    logic [16:0] prev_out;
    logic [15:0] rd_addrs[$];
    logic [16:0] ops[$];
    logic [16:0] lanes[$];
    int          lane_cyc[$];
    logic [16:0] exp_q[$];

    always @(negedge clk) begin
        if (ram_ena) begin
            ops.push_back({|ram_wea, ram_addr});
            if (ram_wea == 8'h00) begin rd_addrs.push_back(ram_addr); issued++; end
            else wea_cnt++;
        end
        if (issued - consumed / 4 > outst_max) outst_max = issued - consumed / 4;
        if (out_valid) begin
            valid_seen = 1'b1;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (prev_stall && (!out_valid || {out_last, out_data} !== prev_out)) stall_err++;
        prev_stall = out_valid && !out_ready;
        prev_out   = {out_last, out_data};
        if (out_valid && out_ready) begin
            lanes.push_back({out_last, out_data});
            lane_cyc.push_back(cyc);
            consumed++;
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic clear_mon();
        start_cyc = -1; first_valid_cyc = -1; done_cyc = -1; done_cnt = 0;
        issued = 0; consumed = 0; outst_max = 0; stall_err = 0; wea_cnt = 0;
        valid_seen = 1'b0; prev_stall = 1'b0;
        rd_addrs.delete(); ops.delete(); lanes.delete(); lane_cyc.delete();
    endtask

    task automatic put_word(input logic [15:0] a, input logic [63:0] v);
        tb_we = 1'b1; tb_wa = a; tb_wd = v; ref_mem[a] = v;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    // Expected stream: words base..base+n-1 (16-bit wrap), MSB lane first, last on final lane.
    task automatic build_expected(input logic [15:0] b, input logic [15:0] n);
        logic [15:0] a;
        logic [63:0] w;
        exp_q.delete();
        for (int i = 0; i < int'(n); i++) begin
            a = b + 16'(i);
            w = ref_mem.exists(a) ? ref_mem[a] : 64'h0;
            for (int l = 0; l < 4; l++)
                exp_q.push_back({(i == int'(n) - 1) && (l == 3), w[63 - 16*l -: 16]});
        end
    endtask

    task automatic run_drain(input logic [15:0] b, input logic [15:0] n, input int inj, output bit to);
        build_expected(b, n);
        clear_mon();
        start = 1'b1; base_addr = b; num_words = n; start_cyc = cyc;
        to = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            if (i == inj) begin start = 1'b1; base_addr = b + 16'h0100; num_words = n + 16'd1; end
            else begin start = 1'b0; base_addr = 16'($urandom); num_words = 16'($urandom); end
            @(negedge clk); #1;
            if (done_cnt != 0) begin to = 1'b0; break; end
        end
        repeat (4) begin @(posedge clk); #1; start = 1'b0; end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
        repeat (3) begin @(posedge clk); #1; end
        n_chk++;
        if ({ram_ena, ram_addr, ram_wea, ram_din, out_valid, out_data, out_last, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ena=%b addr=%h wea=%h din=%h v=%b d=%h l=%b busy=%b done=%b, expected all 0",
                     ram_ena, ram_addr, ram_wea, ram_din, out_valid, out_data, out_last, busy, done);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit to;
        put_word(16'h0010, 64'h0001_0002_0003_0004);
        put_word(16'h0011, 64'h0005_0006_0007_0008);
        ready_mode = 0;
        @(posedge clk); #1;
        run_drain(16'h0010, 16'd2, -1, to);
        n_chk++; if (to) begin n_fail++; $display("FAIL basic_timeout: done never seen"); end
        n_chk++; if (lanes.size() != 8) begin n_fail++; $display("FAIL basic_count: got %0d lanes expected 8", lanes.size()); end
        for (int i = 0; i < 8 && i < lanes.size(); i++) begin
            n_chk++;
            if (lanes[i] !== {(i == 7), 16'(i + 1)}) begin
                n_fail++; $display("FAIL basic_lane%0d: got %h expected %h", i, lanes[i], {(i == 7), 16'(i + 1)});
            end
        end
        n_chk++;
        if (lane_cyc.size() == 8 && lane_cyc[7] - lane_cyc[0] != 7) begin
            n_fail++; $display("FAIL basic_throughput: lanes spanned %0d cycles expected 7", lane_cyc[7] - lane_cyc[0]);
        end
        n_chk++;
        if (first_valid_cyc - start_cyc != int'(RD_LAT) + 1) begin
            n_fail++; $display("FAIL basic_latency: got %0d expected %0d", first_valid_cyc - start_cyc, RD_LAT + 1);
        end
        n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses expected 1", done_cnt); end
        n_chk++;
        if (rd_addrs.size() != 2 || rd_addrs[0] !== 16'h0010 || rd_addrs[1] !== 16'h0011) begin
            n_fail++; $display("FAIL basic_reads: got %0d reads expected 2 at 0010,0011", rd_addrs.size());
        end
`ifndef OUT_DRAIN_CLEAR_EN
        n_chk++; if (wea_cnt != 0) begin n_fail++; $display("FAIL basic_no_write: got %0d writes expected 0", wea_cnt); end
`endif
    endtask

    task automatic test_backpressure();
        bit to;
        put_word(16'h0010, 64'h0001_0002_0003_0004);
        put_word(16'h0011, 64'h0005_0006_0007_0008);
        ready_mode = 1; rphase = 0;
        run_drain(16'h0010, 16'd2, -1, to);
        n_chk++; if (to) begin n_fail++; $display("FAIL bp_timeout: done never seen"); end
        n_chk++; if (lanes.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", lanes.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < lanes.size(); i++) begin
            n_chk++;
            if (lanes[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_lane%0d: got %h expected %h", i, lanes[i], exp_q[i]); end
        end
        n_chk++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_err); end
        n_chk++; if (outst_max > 2) begin n_fail++; $display("FAIL bp_outstanding: got %0d expected <= 2", outst_max); end
        n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_zero_len();
        bit to;
        ready_mode = 0;
        run_drain(16'h0030, 16'd0, -1, to);
        n_chk++; if (to) begin n_fail++; $display("FAIL zero_timeout: done never seen"); end
        n_chk++; if (done_cyc - start_cyc != 2) begin n_fail++; $display("FAIL zero_done_time: got %0d expected 2", done_cyc - start_cyc); end
        n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done_count: got %0d expected 1", done_cnt); end
        n_chk++; if (ops.size() != 0) begin n_fail++; $display("FAIL zero_ram: got %0d accesses expected 0", ops.size()); end
        n_chk++; if (valid_seen) begin n_fail++; $display("FAIL zero_valid: got out_valid=1 expected never"); end
    endtask

    task automatic test_wrap();
        bit to;
        put_word(16'hFFFF, {$urandom, $urandom});
        put_word(16'h0000, {$urandom, $urandom});
        ready_mode = 0;
        run_drain(16'hFFFF, 16'd2, -1, to);
        n_chk++; if (to) begin n_fail++; $display("FAIL wrap_timeout: done never seen"); end
        n_chk++;
        if (rd_addrs.size() != 2 || rd_addrs[0] !== 16'hFFFF || rd_addrs[1] !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_addrs: got %0d reads (first %h) expected FFFF,0000", rd_addrs.size(), rd_addrs.size() ? rd_addrs[0] : 16'h0);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_chk++;
            if (i >= lanes.size() || lanes[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL wrap_lane%0d: got %h expected %h", i, (i < lanes.size()) ? lanes[i] : 17'h0, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_abort();
        bit to, hit;
        for (int w = 0; w < 4; w++) put_word(16'h0040 + 16'(w), {$urandom, $urandom});
        ready_mode = 0;
        build_expected(16'h0040, 16'd4);
        clear_mon();
        start = 1'b1; base_addr = 16'h0040; num_words = 16'd4;
        @(posedge clk); #1; start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (lanes.size() >= 3) begin hit = 1'b1; break; end
        end
        n_chk++; if (!hit) begin n_fail++; $display("FAIL abort_progress: got %0d lanes expected 3", lanes.size()); end
        for (int i = 0; i < 3 && i < lanes.size(); i++) begin
            n_chk++;
            if (lanes[i] !== exp_q[i]) begin n_fail++; $display("FAIL abort_lane%0d: got %h expected %h", i, lanes[i], exp_q[i]); end
        end
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if ({ram_ena, ram_addr, ram_wea, ram_din, out_valid, out_data, out_last, busy, done} !== '0) begin
            n_fail++; $display("FAIL abort_outputs: got v=%b d=%h busy=%b done=%b ena=%b, expected all 0", out_valid, out_data, busy, done, ram_ena);
        end
        rst = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        n_chk++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses expected 0", done_cnt); end
        n_chk++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got v=%b busy=%b expected 0,0", out_valid, busy); end
        // Fresh drain with a start pulse injected mid-drain, which must be ignored.
        run_drain(16'h0040, 16'd4, 3, to);
        n_chk++; if (to) begin n_fail++; $display("FAIL restart_timeout: done never seen"); end
        n_chk++; if (lanes.size() != 16) begin n_fail++; $display("FAIL restart_count: got %0d expected 16", lanes.size()); end
        for (int i = 0; i < exp_q.size() && i < lanes.size(); i++) begin
            n_chk++;
            if (lanes[i] !== exp_q[i]) begin n_fail++; $display("FAIL restart_lane%0d: got %h expected %h", i, lanes[i], exp_q[i]); end
        end
        n_chk++; if (rd_addrs.size() != 4) begin n_fail++; $display("FAIL restart_reads: got %0d expected 4", rd_addrs.size()); end
        n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL restart_done: got %0d expected 1", done_cnt); end
    endtask

`ifdef OUT_DRAIN_CLEAR_EN
    task automatic test_clear();
        bit to;
        for (int w = 0; w < 3; w++) put_word(16'h0020 + 16'(w), {$urandom, $urandom});
        ready_mode = 0;
        run_drain(16'h0020, 16'd3, -1, to);
        n_chk++; if (to) begin n_fail++; $display("FAIL clear_timeout: done never seen"); end
        n_chk++; if (ops.size() != 6) begin n_fail++; $display("FAIL clear_ops: got %0d accesses expected 6", ops.size()); end
        for (int i = 0; i < 6 && i < ops.size(); i++) begin
            n_chk++;
            if (ops[i] !== {1'(i % 2), 16'h0020 + 16'(i / 2)}) begin
                n_fail++; $display("FAIL clear_op%0d: got %h expected %h", i, ops[i], {1'(i % 2), 16'h0020 + 16'(i / 2)});
            end
        end
        for (int w = 0; w < 3; w++) begin
            n_chk++;
            if (mem[16'h0020 + 16'(w)] !== 64'h0) begin n_fail++; $display("FAIL clear_mem%0d: got %h expected 0", w, mem[16'h0020 + 16'(w)]); end
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_chk++;
            if (i >= lanes.size() || lanes[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL clear_lane%0d: got %h expected %h", i, (i < lanes.size()) ? lanes[i] : 17'h0, exp_q[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        bit to;
        logic [15:0] b, n;
        for (int it = 0; it < 8; it++) begin
            b = (it % 3 == 0) ? 16'hFFFE : 16'($urandom);
            n = 16'($urandom_range(1, 5));
            for (int w = 0; w < int'(n); w++) put_word(b + 16'(w), {$urandom, $urandom});
            ready_mode = 2;
            run_drain(b, n, (it % 2 == 0) ? 2 : -1, to);
            n_chk++; if (to) begin n_fail++; $display("FAIL rand%0d_timeout: done never seen", it); end
            n_chk++; if (lanes.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d", it, lanes.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < lanes.size(); i++) begin
                n_chk++;
                if (lanes[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_lane%0d: got %h expected %h", it, i, lanes[i], exp_q[i]); end
            end
            n_chk++; if (rd_addrs.size() != int'(n)) begin n_fail++; $display("FAIL rand%0d_reads: got %0d expected %0d", it, rd_addrs.size(), n); end
            n_chk++; if (outst_max > 2) begin n_fail++; $display("FAIL rand%0d_outstanding: got %0d expected <= 2", it, outst_max); end
            n_chk++; if (stall_err != 0) begin n_fail++; $display("FAIL rand%0d_stable: got %0d expected 0", it, stall_err); end
            n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL rand%0d_done: got %0d expected 1", it, done_cnt); end
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_wrap();
        test_reset_abort();
`ifdef OUT_DRAIN_CLEAR_EN
        test_clear();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/out_buf_drain.md
Name: out_buf_drain

Overview:
- Reads packed partial-sum words (4 x 16-bit lanes per 64-bit word) out of the output buffer RAM once a layer completes.
- Unpacks each word and streams the lanes one at a time on a valid/ready interface toward the next-layer loader or host link.
- Acts as the reader at the far end of the output-buffer path, whose writer is the data-pack / out-address logic.
- Owns the output buffer's port only while busy; the accelerator controller owns it otherwise.

Parameters:
- ADDR_W, 16, RAM word-address width.
- DATA_W, 64, RAM word width; must equal LANES*LANE_W.
- LANE_W, 16, width of one partial sum.
- LANES, 4, lanes per RAM word.
- RD_LAT, 1, RAM read latency in cycles (ena/addr to dout valid); supported values 1 and 2.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse (layer_ready); begins a drain.
- base_addr  in  ADDR_W  first word address; sampled on start.
- num_words  in  ADDR_W  number of words to drain; sampled on start.
- ram_ena  out  1  RAM enable.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wea  out  8  byte write enable; used only with the optional feature.
- ram_din  out  DATA_W  RAM write data; always zero.
- ram_dout  in  DATA_W  RAM read data, valid RD_LAT cycles after a read.
- out_valid  out  1  lane data valid.
- out_ready  in  1  downstream accepts the lane.
- out_data  out  LANE_W  current lane.
- out_last  out  1  final lane of the drain.
- busy  out  1  drain in progress.
- done  out  1  one-cycle pulse when the drain completes.

Behaviour:
- Reset: all outputs are 0; FSM enters IDLE; FIFO, lane counter, read counter and in-flight counter are cleared.
- FSM states are IDLE, READ, FLUSH, DONE.
- IDLE: start latches base_addr/num_words and sets busy. num_words != 0 goes to READ; num_words == 0 goes directly to DONE with no RAM access.
- READ issuing rule: one read per cycle (ram_ena=1, ram_addr=next address) when FIFO occupancy + in-flight reads < 2. Address increments after each issue.
- READ exit: after the num_words-th issue, go to FLUSH.
- Address arithmetic wraps modulo 2^ADDR_W (0xFFFF+1 -> 0x0000); no error flag.
- Returned data: RD_LAT cycles after each issue, ram_dout is written into a 2-entry word FIFO. Credit-based issuing guarantees the FIFO never overflows.
- Unpacking: the FIFO head is emitted MSB lane first: lane0=[63:48], lane1=[47:32], lane2=[31:16], lane3=[15:0].
- Handshake: out_valid stays high while the FIFO is non-empty. out_data and out_last hold stable while out_valid && !out_ready. A transfer occurs when out_valid && out_ready.
- Lane counter advances on each transfer. After lane LANES-1 it pops the FIFO and resets to 0.
- out_last is high only on lane LANES-1 of word num_words-1.
- FLUSH: wait until in-flight == 0 and the FIFO is empty, then go to DONE.
- DONE: done=1 for exactly one cycle, busy drops in the same cycle, then return to IDLE.
- start while busy is ignored, with no effect on the latched parameters.
- Throughput: with out_ready held high, one lane per cycle sustained and no bubbles between words. First out_valid appears RD_LAT+1 cycles after start.
- rst mid-drain: aborts on the next edge, discards in-flight data, and does not pulse done.

Optional Feature:
- OUT_DRAIN_CLEAR_EN defined:
  - Each read is followed by a clear cycle at the same address: ram_ena=1, ram_wea=8'hFF, ram_din=0.
  - Reads and clears alternate, so the issue rate halves (one word per 2 cycles).
  - The buffer is left zeroed for the next layer's accumulation.
  - Credit rules are unchanged; clears never consume credits.
- Undefined: ram_wea is tied to 0 and no clear cycles occur.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE/READ/FLUSH/DONE);
  - lane-order constants;
  - ADDR_W/LANE_W/LANES defaults, shared with data_pack and out_addr_rdy.
- One sub-module, drain_word_fifo: 2-entry, DATA_W-wide synchronous FIFO with count output, push/pop, and simultaneous push+pop at full supported.

Test Plan:
- Basic drain: RAM[0x10..0x11] = 64'h0001_0002_0003_0004 and 64'h0005_0006_0007_0008; start with base=0x10, num=2, out_ready=1.
  -> 8 lanes 0x0001..0x0008 on consecutive cycles, out_last only on 0x0008, done pulses once, exactly 2 reads issued.
- Backpressure: same data, out_ready toggling 1,0,0,1,...
  -> out_data is stable during stalls, no lane is lost or duplicated, reads never exceed 2 outstanding.
- Zero length: num=0.
  -> no ram_ena; done pulses 2 cycles after start; out_valid never asserted.
- Wrap: base=0xFFFF, num=2.
  -> reads issued at addresses 0xFFFF then 0x0000.
- Reset and ignored start: rst asserted after 3 lanes of a 4-word drain.
  -> next cycle all outputs are 0 with no done pulse. A new start then drains correctly. A start pulsed mid-drain is ignored.
- Clear mode (OUT_DRAIN_CLEAR_EN): base=0x20, num=3.
  -> read/clear alternate at 0x20,0x20,0x21,0x21,0x22,0x22. Afterwards RAM[0x20..0x22] = 0 and the streamed data matches the pre-drain contents.
